// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified-RAM memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Anything other than a byte or halfword access is handled as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        return ((len == LEN_B) || (len == LEN_H)) ? len : LEN_W;
    endfunction

endpackage

// File: rtl/mem_ctrl_fbuf.sv
// One-entry instruction fetch buffer: remembers the last fetched word and
// drops it when a store touches any of its four bytes.
module mem_ctrl_fbuf
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [31:0]       fill_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] inval_addr,
    input  logic [2:0]        inval_len
);

    logic              valid_reg;
    logic [ADDR_W-1:0] tag_reg;
    logic [31:0]       data_reg;

    logic [ADDR_W-1:0] fwd_dist;
    logic [ADDR_W-1:0] back_dist;
    logic              overlap;

    // Modular distances make the overlap test correct across address wrap:
    // either the store starts inside the word, or the word starts inside the store.
    assign fwd_dist  = inval_addr - tag_reg;
    assign back_dist = tag_reg - inval_addr;
    assign overlap   = (fwd_dist < ADDR_W'(4)) || (back_dist < ADDR_W'(inval_len));

    assign hit      = valid_reg && (tag_reg == lookup_addr);
    assign hit_data = data_reg;

    // Buffer entry update: invalidation by an overlapping store, refill on fetch completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= ZERO_WORD;
        end else if (inval && overlap) begin
            valid_reg <= 1'b0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_addr;
            data_reg  <= fill_data;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates one byte-wide RAM between instruction fetch
// and data access, sequencing multi-byte accesses one byte per cycle.
// Optional one-entry fetch buffer enabled by defining MEM_CTRL_IFETCH_BUF_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    input  logic              jump_i,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [2:0]        len_reg, len_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
    logic [7:0]        ram_dout_reg, ram_dout_next;
    logic              ram_wr_reg, ram_wr_next;
    logic [DATA_W-1:0] if_data_reg, if_data_next;
    logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
    logic              if_done_reg, if_done_next;
    logic              mem_done_reg, mem_done_next;

    logic              issue_more;
    logic              last_byte;
    logic [1:0]        byte_idx;
    logic [1:0]        wr_idx;
    logic [ADDR_W-1:0] next_addr;
    logic              fb_hit;
    logic [31:0]       fb_data;

    // cnt counts cycles since the first address went out; reads capture
    // byte cnt-1 because RAM data lags its address by one cycle.
    assign issue_more = (cnt_reg + 3'd1) < len_reg;
    assign last_byte  = (cnt_reg == len_reg);
    assign byte_idx   = 2'(cnt_reg - 3'd1);
    assign wr_idx     = 2'(cnt_reg + 3'd1);
    assign next_addr  = addr_reg + ADDR_W'(cnt_reg + 3'd1);

`ifdef MEM_CTRL_IFETCH_BUF_EN
    logic fb_fill;
    logic fb_inval;

    assign fb_fill  = (state_reg == IF_RD) && !jump_i && last_byte;
    assign fb_inval = (state_reg == IDLE) && !if_done_reg && !mem_done_reg && mem_req && mem_we;

    mem_ctrl_fbuf #(
        .ADDR_W (ADDR_W)
    ) u_fbuf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (if_addr),
        .hit         (fb_hit),
        .hit_data    (fb_data),
        .fill        (fb_fill),
        .fill_addr   (addr_reg),
        .fill_data   (if_data_next),
        .inval       (fb_inval),
        .inval_addr  (mem_addr),
        .inval_len   (norm_len(mem_len))
    );
`else
    assign fb_hit  = 1'b0;
    assign fb_data = ZERO_WORD;
`endif

    // Sequencer: arbitration in IDLE, then one RAM byte per cycle.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        wdata_next     = wdata_reg;
        ram_a_next     = ram_a_reg;
        ram_dout_next  = ram_dout_reg;
        ram_wr_next    = 1'b0;
        if_data_next   = if_data_reg;
        mem_rdata_next = mem_rdata_reg;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // A request still high in its done cycle is the old one; skip it.
                if (!if_done_reg && !mem_done_reg) begin
                    if (mem_req) begin
                        addr_next  = mem_addr;
                        len_next   = norm_len(mem_len);
                        wdata_next = mem_wdata;
                        cnt_next   = 3'd0;
                        ram_a_next = mem_addr;
                        if (mem_we) begin
                            state_next    = MEM_WR;
                            ram_wr_next   = 1'b1;
                            ram_dout_next = mem_wdata[7:0];
                        end else begin
                            state_next     = MEM_RD;
                            mem_rdata_next = DATA_W'(ZERO_WORD);
                        end
                    end else if (if_req && !jump_i) begin
                        if (fb_hit) begin
                            if_data_next = DATA_W'(fb_data);
                            if_done_next = 1'b1;
                        end else begin
                            addr_next  = if_addr;
                            len_next   = LEN_W;
                            cnt_next   = 3'd0;
                            ram_a_next = if_addr;
                            state_next = IF_RD;
                        end
                    end
                end
            end

            IF_RD: begin
                if (jump_i) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    if (issue_more) begin
                        ram_a_next = next_addr;
                    end
                    if (cnt_reg != 3'd0) begin
                        if_data_next[{byte_idx, 3'b000} +: 8] = ram_din;
                    end
                    if (last_byte) begin
                        if_done_next = 1'b1;
                        state_next   = IDLE;
                        cnt_next     = 3'd0;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end

            MEM_RD: begin
                if (issue_more) begin
                    ram_a_next = next_addr;
                end
                if (cnt_reg != 3'd0) begin
                    mem_rdata_next[{byte_idx, 3'b000} +: 8] = ram_din;
                end
                if (last_byte) begin
                    mem_done_next = 1'b1;
                    state_next    = IDLE;
                    cnt_next      = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end

            MEM_WR: begin
                if (issue_more) begin
                    ram_wr_next   = 1'b1;
                    ram_a_next    = next_addr;
                    ram_dout_next = wdata_reg[{wr_idx, 3'b000} +: 8];
                    cnt_next      = cnt_reg + 3'd1;
                end else begin
                    mem_done_next = 1'b1;
                    state_next    = IDLE;
                    cnt_next      = 3'd0;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            addr_reg      <= '0;
            len_reg       <= LEN_W;
            wdata_reg     <= '0;
            ram_a_reg     <= '0;
            ram_dout_reg  <= 8'h00;
            ram_wr_reg    <= 1'b0;
            if_data_reg   <= '0;
            mem_rdata_reg <= '0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            wdata_reg     <= wdata_next;
            ram_a_reg     <= ram_a_next;
            ram_dout_reg  <= ram_dout_next;
            ram_wr_reg    <= ram_wr_next;
            if_data_reg   <= if_data_next;
            mem_rdata_reg <= mem_rdata_next;
            if_done_reg   <= if_done_next;
            mem_done_reg  <= mem_done_next;
        end
    end

    assign if_data       = if_data_reg;
    assign if_done       = if_done_reg;
    assign mem_rdata     = mem_rdata_reg;
    assign mem_done      = mem_done_reg;
    assign ram_a         = ram_a_reg;
    assign ram_dout      = ram_dout_reg;
    assign ram_wr        = ram_wr_reg;
    assign stall_req_if  = if_req & ~if_done_reg;
    assign stall_req_mem = mem_req & ~mem_done_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// fetch/load/store traffic compared against a byte-array reference model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_IFETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, jump_i = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [2:0]  mem_len = 3'd4;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic        if_done, mem_done, stall_req_if, stall_req_mem, ram_wr;
    logic [7:0]  ram_dout, ram_din;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .jump_i(jump_i), .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    // RAM model (4 KiB, aliased) with a backdoor write port for preloading.
    logic [7:0]  ram_mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) ram_mem[bd_addr] <= bd_data;
        else if (ram_wr) ram_mem[ram_a[11:0]] <= ram_dout;
        ram_din <= ram_mem[ram_a[11:0]];
    end

    // Reference model state
    logic [7:0]  ref_mem [0:4095];
    bit          fb_valid = 1'b0;
    logic [31:0] fb_addr = '0, fb_data = '0;
    int          checks = 0, errors = 0, txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic int nlen(input logic [2:0] l);
        return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[12'(a + 32'(k))];
        return r;
    endfunction

    // Waits (bounded) for the selected done pulse; lat = cycles after T, -1 on timeout.
    task automatic wait_done(input bit want_if, output int lat, output int wr_cnt,
                             output logic [31:0] first_a);
        lat = -1; wr_cnt = 0; first_a = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) first_a = ram_a;
            if (ram_wr) wr_cnt++;
            if (want_if ? if_done : mem_done) begin lat = n; break; end
        end
    endtask

    task automatic run_fetch(input logic [31:0] a);
        int lat, wc, exp_lat;
        logic [31:0] exp_d, a0, fa;
        bit hit;
        hit = BUF_EN && fb_valid && (fb_addr == a);
        exp_lat = hit ? 1 : 6;
        exp_d = hit ? fb_data : ref_read(a, 4);
        a0 = ram_a;
        if_addr = a; if_req = 1'b1; #1;
        chk("fetch_stall_T", 32'(stall_req_if), 32'd1);
        wait_done(1'b1, lat, wc, fa);
        chk("fetch_stall_done", 32'(stall_req_if), 32'd0);
        if_req = 1'b0;
        chk("fetch_lat", lat, exp_lat);
        chk("fetch_data", if_data, exp_d);
        chk("fetch_no_wr", wc, 0);
        chk("fetch_first_a", fa, hit ? a0 : a);
        fb_valid = 1'b1; fb_addr = a; fb_data = exp_d;
        txn++;
        $display("txn %0d fetch addr=%h data=%h lat=%0d", txn, a, if_data, lat);
        step();
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] l);
        int lat, wc, n;
        logic [31:0] fa;
        n = nlen(l);
        mem_addr = a; mem_len = l; mem_we = 1'b0; mem_req = 1'b1; #1;
        chk("load_stall_T", 32'(stall_req_mem), 32'd1);
        wait_done(1'b0, lat, wc, fa);
        chk("load_stall_done", 32'(stall_req_mem), 32'd0);
        mem_req = 1'b0;
        chk("load_lat", lat, n + 2);
        chk("load_data", mem_rdata, ref_read(a, n));
        chk("load_first_a", fa, a);
        chk("load_no_wr", wc, 0);
        txn++;
        $display("txn %0d load addr=%h len=%0d data=%h lat=%0d", txn, a, l, mem_rdata, lat);
        step();
    endtask

    task automatic run_store(input logic [31:0] a, input logic [2:0] l, input logic [31:0] wd);
        int lat, wc, n;
        logic [31:0] fa, ba;
        n = nlen(l);
        mem_addr = a; mem_len = l; mem_we = 1'b1; mem_wdata = wd; mem_req = 1'b1; #1;
        wait_done(1'b0, lat, wc, fa);
        mem_req = 1'b0; mem_we = 1'b0;
        chk("store_lat", lat, n + 1);
        chk("store_wr_cnt", wc, n);
        chk("store_first_a", fa, a);
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            ref_mem[ba[11:0]] = wd[8*k +: 8];
            if ((ba - fb_addr) < 32'd4) fb_valid = 1'b0;
        end
        txn++;
        $display("txn %0d store addr=%h len=%0d wdata=%h lat=%0d", txn, a, l, wd, lat);
        step();
    endtask

    initial begin
        int ilat, mlat, wc;
        logic [31:0] idata, mdata, wd, fa, last_fetch;
        logic [7:0] v;

        // Preload RAM during reset
        for (int i = 0; i < 4096; i++) begin
            v = (i < 4) ? ((i == 0) ? 8'h13 : 8'h00) : 8'($urandom);
            bd_we = 1'b1; bd_addr = 12'(i); bd_data = v; ref_mem[i] = v;
            step();
        end
        bd_we = 1'b0;
        step();
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        rst = 1'b0;
        step();

        // Basic fetch of 0x00000013
        run_fetch(32'h0);
        chk("fetch0_const", if_data, 32'h0000_0013);

        // Simultaneous requests: MEM wins, IF follows
        ilat = -1; mlat = -1; idata = '0; mdata = '0;
        if_addr = 32'h20; mem_addr = 32'h10; mem_len = 3'd4; mem_we = 1'b0;
        if_req = 1'b1; mem_req = 1'b1; #1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (mem_done && mlat < 0) begin mlat = n; mdata = mem_rdata; mem_req = 1'b0; end
            if (if_done) begin ilat = n; idata = if_data; if_req = 1'b0; break; end
        end
        chk("arb_mem_lat", mlat, 6);
        chk("arb_mem_data", mdata, ref_read(32'h10, 4));
        chk("arb_if_lat", ilat, 13);
        chk("arb_if_data", idata, ref_read(32'h20, 4));
        fb_valid = 1'b1; fb_addr = 32'h20; fb_data = ref_read(32'h20, 4);
        txn++;
        $display("txn %0d arb mem_lat=%0d if_lat=%0d", txn, mlat, ilat);
        step();

        // Halfword store then byte load
        run_store(32'h100, 3'd2, 32'h0000_BEEF);
        run_load(32'h101, 3'd1);
        chk("load_be_const", mem_rdata, 32'h0000_00BE);

        // jump_i during a fetch: abort, new PC accepted at T+4, done at T+10
        ilat = -1;
        if_addr = 32'h80; if_req = 1'b1; #1;
        for (int n = 1; n <= 40; n++) begin
            step();
            jump_i = (n == 3);
            if (n == 4) if_addr = 32'h90;
            if (if_done) begin ilat = n; break; end
        end
        jump_i = 1'b0; if_req = 1'b0;
        chk("jump_if_lat", ilat, 10);
        chk("jump_if_data", if_data, ref_read(32'h90, 4));
        fb_valid = 1'b1; fb_addr = 32'h90; fb_data = ref_read(32'h90, 4);
        txn++;
        $display("txn %0d jump fetch lat=%0d data=%h", txn, ilat, if_data);
        step();

        // jump_i during a word load: ignored
        mlat = -1;
        mem_addr = 32'h10; mem_len = 3'd4; mem_we = 1'b0; mem_req = 1'b1; #1;
        for (int n = 1; n <= 40; n++) begin
            step();
            jump_i = (n == 3);
            if (mem_done) begin mlat = n; break; end
        end
        jump_i = 1'b0; mem_req = 1'b0;
        chk("jump_mem_lat", mlat, 6);
        chk("jump_mem_data", mem_rdata, ref_read(32'h10, 4));
        txn++;
        $display("txn %0d jump load lat=%0d data=%h", txn, mlat, mem_rdata);
        step();

        // Reset in the middle of a word store
        wd = $urandom;
        mem_addr = 32'h300; mem_len = 3'd4; mem_we = 1'b1; mem_wdata = wd; mem_req = 1'b1;
        step();                 // T+1
        step();                 // T+2
        rst = 1'b1;
        step();                 // T+3
        chk("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mid_rst_ram_a", ram_a, 32'd0);
        chk("mid_rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("mid_rst_if_data", if_data, 32'd0);
        chk("mid_rst_mem_done", 32'(mem_done), 32'd0);
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        step();                 // T+4
        chk("post_rst_ram_wr", 32'(ram_wr), 32'd0);
        ref_mem[12'h300] = wd[7:0];
        ref_mem[12'h301] = wd[15:8];
        fb_valid = 1'b0;
        txn++;
        $display("txn %0d store aborted by reset addr=300 wdata=%h", txn, wd);
        step();
        run_load(32'h300, 3'd4);

        // Fetch-buffer scenario (timing follows the build configuration)
        run_fetch(32'h40);
        run_fetch(32'h40);
        run_store(32'h42, 3'd1, $urandom);
        run_fetch(32'h40);

        // Address wrap-around
        run_load(32'hFFFF_FFFE, 3'd4);

        // Random traffic
        last_fetch = 32'h40;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    fa = ($urandom_range(0, 2) == 0) ? last_fetch : 32'($urandom_range(0, 4095));
                    run_fetch(fa);
                    last_fetch = fa;
                end
                1: run_load(32'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)));
                default: run_store(32'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)), $urandom);
            endcase
        end
        wc = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
